// File: rtl/timer_pkg.sv
// Shared constants for the memory-mapped interval timer: FSM encoding,
// register word offsets, CTRL field positions and the bridge decode window.
package timer_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_CNT  = 2'd2;
    localparam logic [1:0] ST_INT  = 2'd3;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PRESET = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_MODE_MSB = 2;
    localparam int CTRL_IM_BIT   = 3;

    localparam logic [1:0] MODE_ONESHOT  = 2'd0;
    localparam logic [1:0] MODE_PERIODIC = 2'd1;

    localparam logic [31:0] TIMER_BASE = 32'h0000_7F00;
    localparam logic [31:0] TIMER_END  = 32'h0000_7F0B;

    function automatic logic [31:0] pack_ctrl(input logic en, input logic [1:0] mode,
                                              input logic im);
        logic [31:0] v;
        v = '0;
        v[CTRL_EN_BIT]                 = en;
        v[CTRL_MODE_MSB:CTRL_MODE_LSB] = mode;
        v[CTRL_IM_BIT]                 = im;
        return v;
    endfunction

endpackage

// File: rtl/timer_dev.sv
// Interval timer responder: CTRL/PRESET/COUNT registers, down-counter FSM
// and interrupt request to CP0.
module timer_dev
    import timer_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Addr,
    input  logic        WE,
    input  logic [31:0] WD,
    output logic [31:0] RD,
    output logic        IRQ
);

    logic [1:0]  state;
    logic        ctrl_en;
    logic [1:0]  ctrl_mode;
    logic        ctrl_im;
    logic [31:0] preset;
    logic [31:0] count;
    logic        irq_flag;
    logic [1:0]  reg_sel;

    assign reg_sel = Addr[3:2];

    // The bridge has already decoded the window; only the word index matters here.
    logic unused_addr;
    assign unused_addr = ^{Addr[31:4], Addr[1:0]};

    // CPU writes are applied after the FSM update so they win on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            ctrl_en   <= 1'b0;
            ctrl_mode <= MODE_ONESHOT;
            ctrl_im   <= 1'b0;
            preset    <= '0;
            count     <= '0;
            irq_flag  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (ctrl_en) state <= ST_LOAD;
                ST_LOAD: begin
                    count <= preset;
                    state <= ST_CNT;
                end
                ST_CNT: begin
                    if (!ctrl_en) begin
                        state <= ST_IDLE;
                    end else if (count > 32'd1) begin
                        count <= count - 32'd1;
                    end else begin
                        // A preset of 0 lands here straight away, just like a preset of 1.
                        count    <= '0;
                        irq_flag <= 1'b1;
                        state    <= ST_INT;
                    end
                end
                default: begin
                    if (ctrl_mode == MODE_PERIODIC) irq_flag <= 1'b0;
                    else                            ctrl_en  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase

            if (WE) begin
                case (reg_sel)
                    REG_CTRL: begin
                        ctrl_en   <= WD[CTRL_EN_BIT];
                        ctrl_mode <= WD[CTRL_MODE_MSB:CTRL_MODE_LSB];
                        ctrl_im   <= WD[CTRL_IM_BIT];
                        irq_flag  <= 1'b0;
                    end
                    REG_PRESET: begin
                        preset   <= WD;
                        irq_flag <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        RD = '0;
        case (reg_sel)
            REG_CTRL:   RD = pack_ctrl(ctrl_en, ctrl_mode, ctrl_im);
            REG_PRESET: RD = preset;
            REG_COUNT:  RD = count;
            default:    RD = '0;
        endcase
    end

    assign IRQ = ctrl_im & irq_flag;

endmodule

// File: doc/timer_dev.md
# timer_dev

Memory-mapped interval timer answering word accesses in the 0x00007F00–0x00007F0B device window. Responder side of the data-memory bus. The CPU-side bridge decodes the window, filters illegal accesses (sub-word and stores to COUNT trap as AdES/AdEL), and forwards legal word reads and writes here. Exposes CTRL, PRESET and COUNT registers, counts down each clock, and raises an interrupt request to the CP0 hardware-interrupt input.

## Interface
- No parameters.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low; 0 clears all state immediately.
- `Addr`  in  32  byte address; only `Addr[3:2]` is decoded (0 = CTRL, 1 = PRESET, 2 = COUNT, 3 = unmapped).
- `WE`  in  1  write strobe, already qualified by the bridge's window hit.
- `WD`  in  32  write data.
- `RD`  out  32  combinational read data for `Addr[3:2]`.
- `IRQ`  out  1  interrupt request = CTRL.IM & irq_flag.

## Operation
- CTRL register:
  - [0] Enable, [2:1] Mode, [3] IM.
  - [31:4] read 0; writes to them are ignored.
  - Mode 0: one-shot. Mode 1: periodic. Modes 2 and 3 behave as mode 0.
- PRESET: full 32-bit read/write.
- COUNT: read-only. A write with `Addr[3:2]`=2 or 3 is ignored.
- A write to CTRL or PRESET clears irq_flag in the same edge.
- RD for `Addr[3:2]`=3 is 0.
- State machine, states IDLE, LOAD, CNT, INT:
  - IDLE: if Enable → LOAD; else stay.
  - LOAD: COUNT←PRESET; → CNT.
  - CNT:
    - If Enable is 0 → IDLE, COUNT holds.
    - Else if COUNT>1 → COUNT−1.
    - Else → COUNT←0, irq_flag←1, → INT.
  - INT:
    - Mode 0: Enable←0, → IDLE; irq_flag stays set until a CTRL/PRESET write.
    - Mode 1: irq_flag←0, → IDLE. IDLE then reloads because Enable is still 1.
- PRESET=0 behaves as PRESET=1.
- A PRESET write during CNT does not affect the running count; the new value is used at the next LOAD.
- Simultaneous events:
  - A CPU write to CTRL in the same cycle as an INT-state update: CPU-written fields win (Enable, Mode, IM) and irq_flag is cleared.
  - A CPU write in the CNT cycle that reaches zero: the register write applies, but the CNT→INT transition still occurs and sets irq_flag. The write clears irq_flag only when the write is to CTRL or PRESET; in that case the clear wins.
- Wrap-around: none. COUNT never decrements below 0.

## Timing
- Reset values:
  - CTRL=0, PRESET=0, COUNT=0, irq_flag=0, state IDLE.
  - IRQ=0; RD reflects the reset registers.
- Register writes become visible on RD in the cycle after the write edge.
- Enable written at edge t, PRESET=N≥1:
  - LOAD at t+1.
  - COUNT=N and state CNT at t+2.
  - COUNT=1 at t+1+N.
  - COUNT=0, state INT, IRQ=1 (if IM) at t+2+N.
- Mode 0:
  - Enable reads 0 from t+3+N.
  - IRQ stays high until the next CTRL/PRESET write edge.
- Mode 1:
  - IRQ is a 1-cycle pulse.
  - Period is N+3 cycles (INT, IDLE, LOAD, then N counts).
- Clearing Enable mid-count: state IDLE at the next edge, COUNT frozen.
- Re-enabling reloads from PRESET.
- Reset asserted mid-operation: all state returns to reset values asynchronously. Counting resumes only after reset deasserts and a CTRL write sets Enable.

## Structure
- Shared package `timer_pkg` holds:
  - state encoding (IDLE/LOAD/CNT/INT, 2 bits);
  - register offsets (CTRL=0, PRESET=1, COUNT=2 as word index);
  - CTRL bit positions;
  - mode constants (MODE_ONESHOT=0, MODE_PERIODIC=1);
  - the window base 0x00007F00 and end 0x00007F0B, for the bridge's decoder.
- Single flat module; no sub-module.

## Test plan
- Reset check: hold reset=0 mid-count after PRESET=5, Enable=1 → RD of CTRL, PRESET and COUNT all 0; IRQ=0; counting does not resume after release.
- One-shot: PRESET=5, then CTRL=0x9 (IM=1, mode 0, Enable=1) at edge t → COUNT=5 at t+2; COUNT=0 and IRQ=1 at t+7; CTRL reads 0x8 at t+8; IRQ stays high until a PRESET write, then low the next cycle.
- Periodic: PRESET=3, CTRL=0xB → IRQ 1-cycle pulses at t+5, t+11, t+17 (period 6).
- Mid-count disable: PRESET=10, Enable, then write CTRL=0x8 when COUNT=6 → COUNT holds at 6 (±1 for write latency), no IRQ. Re-enable → COUNT=10 two cycles later.
- Masked and boundary cases:
  - IM=0 in mode 0 → IRQ stays 0, irq_flag set; setting IM alone also clears it (it is a CTRL write), so IRQ stays 0.
  - PRESET=0 → INT at t+3.
  - Write to COUNT → ignored.
  - Read of `Addr[3:2]`=3 → 0.
